product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products into a saturating accumulator and presents the
// result with a valid/ready handshake; the next block starts after the result is taken.
module product_accumulator #(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*WIDTH-1:0]     in_product,
   input  logic                   acc_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_WIDTH-1:0]   out_sum,
   output logic                   out_overflow
);

   localparam int CNT_W = $clog2(COUNT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                 state_r, state_s;
   logic [ACC_WIDTH-1:0]   acc_r, acc_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic                   ovf_r, ovf_s;
   logic                   out_valid_r, out_valid_s;
   logic [ACC_WIDTH-1:0]   out_sum_r, out_sum_s;
   logic                   out_ovf_r, out_ovf_s;

   logic [ACC_WIDTH:0]     prod_ext_s;
   logic [ACC_WIDTH:0]     sum_wide_s;
   logic [ACC_WIDTH-1:0]   sat_sum_s;
   logic                   sat_ovf_s;
   logic                   in_ready_s;

   // Acceptance: only while accumulating, not clearing, and never during reset
   assign in_ready_s = rst_n && (state_r == ST_ACCUM) && !acc_clr;

   // Saturating adder; once the sticky bit is set the accumulator stays pinned at all-ones
   always_comb begin
      prod_ext_s = {{(ACC_WIDTH - 2*WIDTH + 1){1'b0}}, in_product};
      sum_wide_s = {1'b0, acc_r} + prod_ext_s;
      if (sum_wide_s[ACC_WIDTH] || ovf_r) begin
         sat_sum_s = {ACC_WIDTH{1'b1}};
         sat_ovf_s = 1'b1;
      end else begin
         sat_sum_s = sum_wide_s[ACC_WIDTH-1:0];
         sat_ovf_s = 1'b0;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_s     = state_r;
      acc_s       = acc_r;
      cnt_s       = cnt_r;
      ovf_s       = ovf_r;
      out_valid_s = out_valid_r;
      out_sum_s   = out_sum_r;
      out_ovf_s   = out_ovf_r;
      case (state_r)
         ST_ACCUM: begin
            if (acc_clr) begin
               acc_s = '0;
               cnt_s = '0;
               ovf_s = 1'b0;
            end else if (in_valid) begin
               acc_s = sat_sum_s;
               ovf_s = sat_ovf_s;
               cnt_s = cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_s     = ST_HOLD;
                  out_valid_s = 1'b1;
                  out_sum_s   = sat_sum_s;
                  out_ovf_s   = sat_ovf_s;
               end else begin
                  state_s = ST_ACCUM;
               end
            end else begin
               state_s = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_s     = ST_ACCUM;
               acc_s       = '0;
               cnt_s       = '0;
               ovf_s       = 1'b0;
               out_valid_s = 1'b0;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s     = ST_ACCUM;
            acc_s       = '0;
            cnt_s       = '0;
            ovf_s       = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_ACCUM;
         acc_r       <= '0;
         cnt_r       <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_sum_r   <= '0;
         out_ovf_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         cnt_r       <= cnt_s;
         ovf_r       <= ovf_s;
         out_valid_r <= out_valid_s;
         out_sum_r   <= out_sum_s;
         out_ovf_r   <= out_ovf_s;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_r;
   assign out_sum      = out_sum_r;
   assign out_overflow = out_ovf_r;

endmodule
